// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM modulator/demodulator pair.
// - state_t  : demodulator FSM states (IDLE / SETTLE / RUN)
// - win_len  : decimation window length, 2^sample_bits - 1 bits. The modulator
//              and the demodulator both use it, so a loopback decodes exactly.
// - rise_pos / fall_pos : divider counts at which pdm_clk strobes fire
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  function automatic int unsigned win_len(input int unsigned sample_bits);
    return (32'd1 << sample_bits) - 32'd1;
  endfunction

  function automatic int unsigned rise_pos(input int unsigned clk_div);
    return clk_div / 2 - 1;
  endfunction

  function automatic int unsigned fall_pos(input int unsigned clk_div);
    return clk_div - 1;
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock generator.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : run enable; low holds the divider at 0 and pdm_clk low
//   pdm_clk    : registered bit clock, CLK_DIV clk cycles per period
//   rise, fall : single-cycle strobes; pdm_clk goes high/low on the edge
//                that samples the corresponding strobe
module pdm_clkgen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pdm_clk,
  output logic rise,
  output logic fall
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] RISE_AT = DW'(rise_pos(CLK_DIV));
  localparam logic [DW-1:0] FALL_AT = DW'(fall_pos(CLK_DIV));

  logic [DW-1:0] div_q;

  assign rise = en && (div_q == RISE_AT);
  assign fall = en && (div_q == FALL_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_q   <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_q <= fall ? '0 : div_q + 1'b1;
      if (rise) begin
        pdm_clk <= 1'b1;
      end else if (fall) begin
        pdm_clk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pdm_demod.sv
// PDM demodulator: drives pdm_clk, synchronizes pdm_data, and decimates the
// stream with a boxcar ones-counter over windows of 2^SAMPLE_BITS-1 bits.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   en            : enable; low stops pdm_clk and clears the decimator
//   pdm_data      : asynchronous PDM input bit
//   edge_sel      : (PDM_DEMOD_EDGE_SEL_EN only) 0 = capture on pdm_clk rise,
//                   1 = capture on fall; sampled only while idle
//   pdm_clk       : registered bit clock to the PDM source
//   sample        : ones count of the last completed window
//   sample_valid  : sample held and valid
//   sample_ready  : consumer accepts when sample_valid && sample_ready
//   overrun       : one-cycle pulse, a window overwrote an unconsumed sample
//   busy          : high in SETTLE or RUN
// Build option: define PDM_DEMOD_EDGE_SEL_EN to add the edge_sel port.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS    = 8,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned SETTLE_WINDOWS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   pdm_data,
`ifdef PDM_DEMOD_EDGE_SEL_EN
  input  logic                   edge_sel,
`endif
  output logic                   pdm_clk,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic                   busy
);

  localparam int unsigned W = win_len(SAMPLE_BITS);
  localparam logic [SAMPLE_BITS-1:0] LAST_BIT = SAMPLE_BITS'(W - 1);
  localparam int unsigned SCW = (SETTLE_WINDOWS > 1) ? $clog2(SETTLE_WINDOWS) : 1;
  localparam logic [SCW-1:0] LAST_SETTLE =
    SCW'((SETTLE_WINDOWS > 0) ? SETTLE_WINDOWS - 1 : 0);

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [SAMPLE_BITS-1:0] bit_cnt_q;
  logic [SAMPLE_BITS-1:0] ones_q;
  logic [SCW-1:0]         settle_q;
  logic                   rise, fall, use_fall, strobe;
  logic                   capture, win_end, load, handshake;
  logic [SAMPLE_BITS-1:0] win_ones;

  pdm_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pdm_clk(pdm_clk),
    .rise   (rise),
    .fall   (fall)
  );

`ifdef PDM_DEMOD_EDGE_SEL_EN
  logic sel_q;

  // Channel select is frozen for the whole enabled run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      sel_q <= edge_sel;
    end
  end

  assign use_fall = sel_q;
`else
  assign use_fall = 1'b0;
`endif

  assign strobe    = use_fall ? fall : rise;
  assign capture   = strobe && (state_q != ST_IDLE);
  assign win_end   = capture && (bit_cnt_q == LAST_BIT);
  // Count including the bit captured on this strobe; max W fits in SAMPLE_BITS.
  assign win_ones  = ones_q + {{(SAMPLE_BITS-1){1'b0}}, sync_q[1]};
  assign handshake = sample_valid && sample_ready;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (en) state_d = (SETTLE_WINDOWS > 0) ? ST_SETTLE : ST_RUN;
      ST_SETTLE: if (win_end && (settle_q == LAST_SETTLE)) state_d = ST_RUN;
      ST_RUN:    load = win_end;
      default:   state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      settle_q     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], pdm_data};

      // Partial windows are dropped whenever the decimator leaves or sits in IDLE.
      if (!en || (state_q == ST_IDLE)) begin
        bit_cnt_q <= '0;
        ones_q    <= '0;
        settle_q  <= '0;
      end else if (capture) begin
        if (win_end) begin
          bit_cnt_q <= '0;
          ones_q    <= '0;
          if (state_q == ST_SETTLE) begin
            settle_q <= (settle_q == LAST_SETTLE) ? '0 : settle_q + 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          ones_q    <= win_ones;
        end
      end

      overrun <= load && sample_valid && !handshake;
      if (load) begin
        sample       <= win_ones;
        sample_valid <= 1'b1;
      end else if (handshake) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
